// File: rtl/p2s_ctrl_cond_pkg.sv
// Shared definitions for the p2s sequencer: FSM encoding and slot constants.
package p2s_ctrl_cond_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int         BITS_DEF  = 8;
    localparam logic [2:0] CTR_LAST  = 3'd0;
    localparam logic [2:0] CTR_FIRST = 3'd7;

endpackage

// File: rtl/p2s_ctrl_cond_bit_cnt.sv
// Down counter for serial slot select: load-to-first has priority, decrement stops at zero.
// One-cycle update; no handshake, caller decides when to load or decrement.
module bit_cnt_p2s_ctrl #(
    parameter int             W     = 3,
    parameter logic [W-1:0]   FIRST = '1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = FIRST;
        end else if (dec_i && (cnt_q != '0)) begin
            // Guarded so a stray decrement at zero can never wrap to FIRST.
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= FIRST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/p2s_ctrl_cond.sv
// Sequencer for the 4-lane p2s converter: load strobe on accept, then BITS slots MSB first.
// Slots occupy the BITS cycles after accept; ready only in IDLE or on the last slot, so words run gap-free.
module p2s_ctrl_cond
    import p2s_ctrl_cond_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int CNT_W = 16,
    localparam int CTR_W = $clog2(BITS)
) (
    input  logic             IN_CLK_p2s,
    input  logic             IN_RESET_p2s,
    input  logic             IN_ENB_ctl,
    input  logic             IN_VALID_p2s,
    output logic             OUT_READY_p2s,
    output logic             OUT_ENB_p2s,
    output logic             OUT_VALID_BS,
    output logic [CTR_W-1:0] OUT_CTR_p2s,
    output logic             OUT_SER_VALID,
    output logic             OUT_BUSY,
    output logic [CNT_W-1:0] OUT_WORDS
);

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(BITS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CTR_W-1:0]   ctr;
    logic               ctr_zero;
    logic               ctr_load;
    logic               ctr_dec;
    logic               ready;
    logic               accept;
    logic [CNT_W-1:0]   words_q;
    logic [CNT_W-1:0]   words_d;

    bit_cnt_p2s_ctrl #(
        .W     (CTR_W),
        .FIRST (CTR_INIT)
    ) u_bit_cnt (
        .clk_i  (IN_CLK_p2s),
        .rst_ni (IN_RESET_p2s),
        .load_i (ctr_load),
        .dec_i  (ctr_dec),
        .cnt_o  (ctr),
        .zero_o (ctr_zero)
    );

    always_ff @(posedge IN_CLK_p2s) begin
        if (!IN_RESET_p2s) begin
            state_q <= ST_IDLE;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)               state_d = ST_SHIFT;
            ST_SHIFT: if (ctr_zero && !accept)  state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready    = IN_RESET_p2s && IN_ENB_ctl &&
                   ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && ctr_zero));
        accept   = IN_VALID_p2s && ready;
        // Counter sits at the first slot whenever no word is mid-shift.
        ctr_load = (state_q == ST_IDLE) || ctr_zero;
        ctr_dec  = (state_q == ST_SHIFT) && !ctr_zero;
        words_d  = words_q;
        if (accept && (words_q != '1)) begin
            words_d = words_q + CNT_W'(1);
        end
    end

    assign OUT_READY_p2s = ready;
    assign OUT_ENB_p2s   = accept;
    assign OUT_VALID_BS  = accept;
    assign OUT_CTR_p2s   = ctr;
    assign OUT_SER_VALID = (state_q == ST_SHIFT);
    assign OUT_BUSY      = (state_q == ST_SHIFT);
    assign OUT_WORDS     = words_q;

endmodule

// File: tb/tb_p2s_ctrl_cond.sv
// Bench for p2s_ctrl_cond: queued expectations from a slot-count model, checked by separate monitors.
module tb_p2s_ctrl_cond;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic enb   = 1'b1;
    logic vld   = 1'b1;

    logic        ready, ld, vbs, ser_valid, busy;
    logic [2:0]  ctr;
    logic [15:0] words;

    logic        ready4, ld4, vbs4, ser_valid4, busy4;
    logic [2:0]  ctr4;
    logic [3:0]  words4;

    p2s_ctrl_cond u_dut (
        .IN_CLK_p2s    (clk),
        .IN_RESET_p2s  (rst_n),
        .IN_ENB_ctl    (enb),
        .IN_VALID_p2s  (vld),
        .OUT_READY_p2s (ready),
        .OUT_ENB_p2s   (ld),
        .OUT_VALID_BS  (vbs),
        .OUT_CTR_p2s   (ctr),
        .OUT_SER_VALID (ser_valid),
        .OUT_BUSY      (busy),
        .OUT_WORDS     (words)
    );

    p2s_ctrl_cond #(.CNT_W(4)) u_dut4 (
        .IN_CLK_p2s    (clk),
        .IN_RESET_p2s  (rst_n),
        .IN_ENB_ctl    (enb),
        .IN_VALID_p2s  (vld),
        .OUT_READY_p2s (ready4),
        .OUT_ENB_p2s   (ld4),
        .OUT_VALID_BS  (vbs4),
        .OUT_CTR_p2s   (ctr4),
        .OUT_SER_VALID (ser_valid4),
        .OUT_BUSY      (busy4),
        .OUT_WORDS     (words4)
    );

    typedef struct packed {
        logic rdy;
        logic acc;
    } hs_t;

    int   total = 0;
    int   bad   = 0;
    int   slots_left = 0;
    int   words_m  = 0;
    int   words4_m = 0;
    int   slot_q[$];
    hs_t  hs_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: slots_left = serial slots still to show, counting the one on the wire now.
    task automatic cycle(input logic r, input logic e, input logic v);
        logic exp_rdy;
        logic acc;
        hs_t  h;
        @(negedge clk);
        rst_n = r;
        enb   = e;
        vld   = v;
        #1;
        exp_rdy = r && e && (slots_left <= 1);
        acc     = exp_rdy && v;
        h.rdy   = exp_rdy;
        h.acc   = acc;
        hs_q.push_back(h);
        if (acc) begin
            for (int k = 7; k >= 0; k--) slot_q.push_back(k);
        end
        @(posedge clk);
        if (!r) begin
            slots_left = 0;
            words_m    = 0;
            words4_m   = 0;
            slot_q.delete();
        end else if (acc) begin
            slots_left = 8;
            if (words_m  < 65535) words_m++;
            if (words4_m < 15)    words4_m++;
        end else if (slots_left > 0) begin
            slots_left--;
        end
    endtask

    // Handshake monitor: combinational outputs, mid-cycle.
    initial begin
        hs_t h;
        forever begin
            @(negedge clk);
            #2;
            if (hs_q.size() > 0) begin
                h = hs_q.pop_front();
                chk("ready", 32'(ready), 32'(h.rdy));
                chk("enb_p2s", 32'(ld), 32'(h.acc));
                chk("valid_bs", 32'(vbs), 32'(h.acc));
            end
        end
    end

    // Slot monitor: registered outputs just after each edge.
    initial begin
        logic exp_sv;
        int   exp_ctr;
        forever begin
            @(posedge clk);
            #1;
            exp_sv = (slot_q.size() > 0);
            chk("ser_valid", 32'(ser_valid), 32'(exp_sv));
            chk("busy", 32'(busy), 32'(exp_sv));
            if (exp_sv) begin
                exp_ctr = slot_q.pop_front();
                chk("ctr_slot", 32'(ctr), 32'(exp_ctr));
            end else begin
                chk("ctr_idle", 32'(ctr), 32'd7);
            end
            chk("words", 32'(words), 32'(words_m));
            chk("words_sat4", 32'(words4), 32'(words4_m));
        end
    end

    initial begin
        // Reset held with valid high.
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        // Single word.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);
        // Three back-to-back words.
        repeat (24) cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);
        // Enable dropped while slot 4 is on the wire.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16 && slots_left != 5; i++) cycle(1'b1, 1'b1, 1'b0);
        repeat (12) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);
        // Reset while slot 2 is on the wire.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16 && slots_left != 3; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);
        // Random traffic with occasional resets, then a reset-free stretch to saturate CNT_W=4.
        repeat (300) cycle(($urandom % 64) != 0, ($urandom % 6) != 0, ($urandom % 3) != 0);
        repeat (400) cycle(1'b1, ($urandom % 6) != 0, ($urandom % 3) != 0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);
        chk("words4_final", 32'(words4), 32'd15);
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
